// File: rtl/apb_reg_slave.sv
// APB3 register slave: fourteen read/write registers, a committed-write counter
// and a constant ID word, with a configurable number of access-phase wait states.
module apb_reg_slave #(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic [31:0] PADDR,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  localparam int unsigned NUM_RW    = 14;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);
  localparam logic [3:0]  IDX_COUNT = 4'd14;
  localparam logic [3:0]  IDX_ID    = 4'd15;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt, wait_cnt_nxt;
  logic [5:0]  addr_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic [31:0] regs [NUM_RW];
  logic [31:0] wr_count;

  logic        capture;
  logic        complete;
  logic        xfer_err;
  logic        commit;
  logic [3:0]  reg_idx;
  logic [31:0] rd_data;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    capture      = 1'b0;
    complete     = 1'b0;
    unique case (state)
      IDLE: begin
        if (PSEL) begin
          capture      = 1'b1;
          wait_cnt_nxt = WAIT_INIT;
          state_nxt    = ACCESS;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          // Bridge gave up on the transfer: drop it without touching any state.
          state_nxt    = IDLE;
          wait_cnt_nxt = 4'd0;
        end else if (PENABLE) begin
          if (wait_cnt != 4'd0) begin
            wait_cnt_nxt = wait_cnt - 4'd1;
          end else begin
            complete  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign reg_idx  = addr_q[5:2];
  assign xfer_err = (addr_q[1:0] != 2'b00) || (write_q && (reg_idx >= IDX_COUNT));
  assign commit   = complete && write_q && !xfer_err;

  always_comb begin
    rd_data = 32'd0;
    if (reg_idx == IDX_ID) begin
      rd_data = ID_VALUE;
    end else if (reg_idx == IDX_COUNT) begin
      rd_data = wr_count;
    end else begin
      rd_data = regs[reg_idx];
    end
  end

  assign PREADY  = complete;
  assign PSLVERR = complete && xfer_err;
  assign PRDATA  = (complete && !write_q && !xfer_err) ? rd_data : 32'd0;

  // NOTE: the register file is reset element by element because its reset value is architectural.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      addr_q   <= 6'd0;
      write_q  <= 1'b0;
      wdata_q  <= 32'd0;
      wr_count <= 32'd0;
      for (int i = 0; i < NUM_RW; i++) begin
        regs[i] <= 32'd0;
      end
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (capture) begin
        addr_q  <= PADDR[5:0];
        write_q <= PWRITE;
        wdata_q <= PWDATA;
      end
      if (commit) begin
        regs[reg_idx] <= wdata_q;
        wr_count      <= wr_count + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Directed bench for apb_reg_slave: one instance with one wait state and one with none,
// sharing the APB bus except for their select lines.
module tb_apb_reg_slave;

  localparam logic [31:0] ID_VAL = 32'hA9B0_0001;

  logic        clk = 1'b0;
  logic        reset;
  logic        psel1, psel0;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata1, prdata0;
  logic        pready1, pready0;
  logic        pslverr1, pslverr0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  apb_reg_slave #(.WAIT_STATES(1), .ID_VALUE(ID_VAL)) dut1 (
    .clk(clk), .reset(reset), .PSEL(psel1), .PENABLE(penable), .PADDR(paddr),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1)
  );

  apb_reg_slave #(.WAIT_STATES(0), .ID_VALUE(ID_VAL)) dut0 (
    .clk(clk), .reset(reset), .PSEL(psel0), .PENABLE(penable), .PADDR(paddr),
    .PWRITE(pwrite), .PWDATA(pwdata), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    psel1   = 1'b0;
    psel0   = 1'b0;
    penable = 1'b0;
  endtask

  // One transfer of lat cycles; after the setup cycle the address, data and direction
  // on the bus are scrambled, since only the captured values may matter.
  task automatic xfer(input bit use0, input bit fast, input logic [31:0] addr, input bit wr,
                      input logic [31:0] wdata, input int lat, input bit exp_err,
                      input logic [31:0] exp_rdata, input string tag);
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk);
      #1;
      psel1 = !use0;
      psel0 = use0;
      if (c == 1) begin
        paddr   = addr;
        pwrite  = wr;
        pwdata  = wdata;
        penable = fast;
      end else begin
        paddr   = addr ^ 32'h0000_0024;
        pwrite  = !wr;
        pwdata  = ~wdata;
        penable = 1'b1;
      end
      @(negedge clk);
      check($sformatf("%s c%0d pready", tag, c), {31'd0, use0 ? pready0 : pready1},
            {31'd0, (c == lat)});
      if (c == lat) begin
        check($sformatf("%s pslverr", tag), {31'd0, use0 ? pslverr0 : pslverr1}, {31'd0, exp_err});
        check($sformatf("%s prdata", tag), use0 ? prdata0 : prdata1, exp_rdata);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a write request on the bus: reset must win.
    reset   = 1'b1;
    psel1   = 1'b1;
    psel0   = 1'b1;
    penable = 1'b1;
    paddr   = 32'h0;
    pwrite  = 1'b1;
    pwdata  = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    psel1   = 1'b0;
    psel0   = 1'b0;
    penable = 1'b0;
    @(negedge clk);
    check("reset pready1", {31'd0, pready1}, 32'd0);
    check("reset pslverr1", {31'd0, pslverr1}, 32'd0);
    check("reset prdata1", prdata1, 32'd0);
    check("reset pready0", {31'd0, pready0}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // One wait state: completion in cycle 3.
    xfer(0, 0, 32'h00, 1, 32'hDEAD_BEEF, 3, 0, 32'd0, "wr reg0");
    xfer(0, 0, 32'h00, 0, 32'd0, 3, 0, 32'hDEAD_BEEF, "rd reg0");
    xfer(0, 0, 32'h38, 0, 32'd0, 3, 0, 32'd1, "rd count1");
    xfer(0, 0, 32'h3C, 0, 32'd0, 3, 0, ID_VAL, "rd id");
    idle();

    // Illegal writes and a misaligned read.
    xfer(0, 0, 32'h3C, 1, 32'h0000_0123, 3, 1, 32'd0, "wr id err");
    xfer(0, 0, 32'h3C, 0, 32'd0, 3, 0, ID_VAL, "rd id after");
    xfer(0, 0, 32'h38, 0, 32'd0, 3, 0, 32'd1, "rd count after id");
    xfer(0, 0, 32'h02, 0, 32'd0, 3, 1, 32'd0, "rd misaligned");
    xfer(0, 0, 32'h38, 1, 32'h5555_5555, 3, 1, 32'd0, "wr count err");
    idle();

    // Top register and ignored upper address bits.
    xfer(0, 0, 32'h34, 1, 32'h1313_1313, 3, 0, 32'd0, "wr reg13");
    xfer(0, 0, 32'hFFFF_FF04, 1, 32'hAAAA_5555, 3, 0, 32'd0, "wr reg1 hi");
    xfer(0, 0, 32'h34, 0, 32'd0, 3, 0, 32'h1313_1313, "rd reg13");
    xfer(0, 0, 32'h04, 0, 32'd0, 3, 0, 32'hAAAA_5555, "rd reg1");
    xfer(0, 0, 32'h38, 0, 32'd0, 3, 0, 32'd3, "rd count3");
    idle();

    // PSEL drops during the wait cycle.
    @(posedge clk);
    #1;
    psel1 = 1'b1; penable = 1'b0; paddr = 32'h08; pwrite = 1'b1; pwdata = 32'h1111_1111;
    @(negedge clk);
    check("abort c1 pready", {31'd0, pready1}, 32'd0);
    @(posedge clk);
    #1;
    psel1 = 1'b0; penable = 1'b1;
    @(negedge clk);
    check("abort c2 pready", {31'd0, pready1}, 32'd0);
    idle();
    @(negedge clk);
    check("abort next pready", {31'd0, pready1}, 32'd0);
    xfer(0, 0, 32'h08, 0, 32'd0, 3, 0, 32'd0, "rd reg2 after abort");
    xfer(0, 0, 32'h38, 0, 32'd0, 3, 0, 32'd3, "rd count after abort");
    idle();

    // Reset asserted in the would-be completion cycle.
    @(posedge clk);
    #1;
    psel1 = 1'b1; penable = 1'b0; paddr = 32'h0C; pwrite = 1'b1; pwdata = 32'h2222_2222;
    @(posedge clk);
    #1;
    penable = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; psel1 = 1'b0; penable = 1'b0;
    @(negedge clk);
    check("rst access pready", {31'd0, pready1}, 32'd0);
    check("rst access pslverr", {31'd0, pslverr1}, 32'd0);
    check("rst access prdata", prdata1, 32'd0);
    xfer(0, 0, 32'h0C, 0, 32'd0, 3, 0, 32'd0, "rd reg3 after rst");
    xfer(0, 0, 32'h38, 0, 32'd0, 3, 0, 32'd0, "rd count after rst");
    xfer(0, 0, 32'h00, 0, 32'd0, 3, 0, 32'd0, "rd reg0 after rst");
    idle();

    // Counter wrap via backdoor preload.
    @(negedge clk);
    force dut1.wr_count = 32'hFFFF_FFFF;
    #1;
    release dut1.wr_count;
    xfer(0, 0, 32'h38, 0, 32'd0, 3, 0, 32'hFFFF_FFFF, "rd count preload");
    xfer(0, 0, 32'h10, 1, 32'h0000_0007, 3, 0, 32'd0, "wr reg4 wrap");
    xfer(0, 0, 32'h38, 0, 32'd0, 3, 0, 32'd0, "rd count wrapped");
    xfer(0, 0, 32'h10, 0, 32'd0, 3, 0, 32'd7, "rd reg4");
    idle();

    // No wait states, PSEL and PENABLE raised together: completion in cycle 2.
    xfer(1, 1, 32'h04, 1, 32'd5, 2, 0, 32'd0, "ws0 wr reg1");
    xfer(1, 1, 32'h04, 0, 32'd0, 2, 0, 32'd5, "ws0 rd reg1");
    xfer(1, 1, 32'h38, 0, 32'd0, 2, 0, 32'd1, "ws0 rd count");
    xfer(1, 1, 32'h3C, 1, 32'd9, 2, 1, 32'd0, "ws0 wr id err");
    idle();
    @(negedge clk);
    check("final pready0", {31'd0, pready0}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
